// File: rtl/uart_dram_tx.sv
// uart_dram_tx: on a rising edge of start_Tx, reads BYTE_COUNT bytes from data RAM
// starting at BASE_ADDR and sends each one on an 8N1 UART line, LSB first.
// busy marks ownership of the DRAM read port so the top level can mux addresses.
// Optional feature macro: UART_TX_PARITY_EN inserts an even parity bit after bit 7 (8E1).
module uart_dram_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [15:0] BYTE_COUNT   = 16'd256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_Tx,
  input  logic [7:0]  DRAM_input_data,
  output logic [15:0] DRAM_address_tx,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StStart, StData, StParity, StStop, StDone
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StStart, StData, StStop, StDone
  } state_e;
`endif

  state_e           state;
  logic             start_Tx_d;
  logic             request;
  logic [BaudW-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [15:0]      sent_cnt;
  logic [15:0]      sent_next;
  logic [7:0]       shreg;
  logic             baud_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // Rising-edge detect on the start strobe; a held level only fires once.
  assign request   = start_Tx & ~start_Tx_d;
  assign baud_end  = (baud_cnt == BaudLast);
  assign sent_next = sent_cnt + 16'd1;

  // Transmit sequencer: state, counters and all outputs are registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= StIdle;
      start_Tx_d      <= 1'b0;
      baud_cnt        <= '0;
      bit_cnt         <= 3'd0;
      sent_cnt        <= 16'd0;
      shreg           <= 8'd0;
      DRAM_address_tx <= BASE_ADDR;
      tx              <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit      <= 1'b0;
`endif
    end else begin
      start_Tx_d <= start_Tx;
      done       <= 1'b0;

      unique case (state)
        StIdle: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
          if (request) begin
            if (BYTE_COUNT == 16'd0) begin
              // Nothing to send: acknowledge straight away without claiming the port.
              done  <= 1'b1;
              state <= StDone;
            end else begin
              DRAM_address_tx <= BASE_ADDR;
              sent_cnt        <= 16'd0;
              busy            <= 1'b1;
              state           <= StFetch;
            end
          end
        end

        // Address is presented; the RAM returns data one cycle later.
        StFetch: begin
          state <= StLoad;
        end

        StLoad: begin
          shreg    <= DRAM_input_data;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^DRAM_input_data;
`endif
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= StStart;
        end

        StStart: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx       <= shreg[0];
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        StData: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= StParity;
`else
              tx    <= 1'b1;
              state <= StStop;
`endif
            end else begin
              // Next bit is the one that lands in position 0 after this shift.
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= StStop;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        StStop: begin
          if (baud_end) begin
            baud_cnt <= '0;
            sent_cnt <= sent_next;
            if (sent_next == BYTE_COUNT) begin
              done  <= 1'b1;
              state <= StDone;
            end else begin
              // 16-bit wrap past 16'hFFFF is intentional.
              DRAM_address_tx <= DRAM_address_tx + 16'd1;
              state           <= StFetch;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dram_tx.sv
// Directed bench for uart_dram_tx with CLKS_PER_BIT=4. Four instances cover the normal
// case (base 0010, 2 bytes), address wrap (base FFFF), zero length and a second data set.
module tb_uart_dram_tx;

  localparam int Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  // Request edge to done for two bytes: two frames plus FETCH/LOAD each.
  localparam int LatFull = 2 * (FrameBits * Cpb + 2);

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_w, start_z, start_p;
  logic [7:0] dq_a, dq_w, dq_z, dq_p;
  logic [15:0] addr_a, addr_w, addr_z, addr_p;
  logic tx_a, tx_w, tx_z, tx_p;
  logic busy_a, busy_w, busy_z, busy_p;
  logic done_a, done_w, done_z, done_p;

  logic [7:0] mem [0:65535];

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  int mon_sel = 0;
  logic        mon_tx, mon_busy, mon_done;
  logic [15:0] mon_addr;

  logic [7:0]  rx_q[$];
  logic        stop_q[$];
  logic        par_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  dec_b;
  logic        dec_s, dec_p;
  logic [15:0] dec_a;

  always #5 clk = ~clk;

  uart_dram_tx #(.CLKS_PER_BIT(Cpb), .BASE_ADDR(16'h0010), .BYTE_COUNT(16'd2)) dut_a (
    .clock(clk), .reset(reset), .start_Tx(start_a), .DRAM_input_data(dq_a),
    .DRAM_address_tx(addr_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );
  uart_dram_tx #(.CLKS_PER_BIT(Cpb), .BASE_ADDR(16'hFFFF), .BYTE_COUNT(16'd2)) dut_w (
    .clock(clk), .reset(reset), .start_Tx(start_w), .DRAM_input_data(dq_w),
    .DRAM_address_tx(addr_w), .tx(tx_w), .busy(busy_w), .done(done_w)
  );
  uart_dram_tx #(.CLKS_PER_BIT(Cpb), .BASE_ADDR(16'h0010), .BYTE_COUNT(16'd0)) dut_z (
    .clock(clk), .reset(reset), .start_Tx(start_z), .DRAM_input_data(dq_z),
    .DRAM_address_tx(addr_z), .tx(tx_z), .busy(busy_z), .done(done_z)
  );
  uart_dram_tx #(.CLKS_PER_BIT(Cpb), .BASE_ADDR(16'h0012), .BYTE_COUNT(16'd2)) dut_p (
    .clock(clk), .reset(reset), .start_Tx(start_p), .DRAM_input_data(dq_p),
    .DRAM_address_tx(addr_p), .tx(tx_p), .busy(busy_p), .done(done_p)
  );

  // Synchronous-read RAM model: data valid one cycle after the address.
  always @(posedge clk) begin
    dq_a <= mem[addr_a];
    dq_w <= mem[addr_w];
    dq_z <= mem[addr_z];
    dq_p <= mem[addr_p];
  end

  always @(posedge clk) begin
    if (done_a === 1'b1) done_cnt <= done_cnt + 1;
  end

  always_comb begin
    mon_tx = tx_a; mon_busy = busy_a; mon_done = done_a; mon_addr = addr_a;
    case (mon_sel)
      1: begin mon_tx = tx_w; mon_busy = busy_w; mon_done = done_w; mon_addr = addr_w; end
      2: begin mon_tx = tx_z; mon_busy = busy_z; mon_done = done_z; mon_addr = addr_z; end
      3: begin mon_tx = tx_p; mon_busy = busy_p; mon_done = done_p; mon_addr = addr_p; end
      default: ;
    endcase
  end

  // UART receiver on the selected line, sampling mid-bit.
  initial begin : decoder
    forever begin
      @(negedge clk);
      if (mon_tx === 1'b0) begin
        dec_a = mon_addr;
        repeat (Cpb) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          dec_b[j] = mon_tx;
          repeat (Cpb - 1) @(negedge clk);
        end
`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        dec_p = mon_tx;
        repeat (Cpb - 1) @(negedge clk);
        par_q.push_back(dec_p);
`endif
        @(negedge clk);
        dec_s = mon_tx;
        rx_q.push_back(dec_b);
        stop_q.push_back(dec_s);
        addr_q.push_back(dec_a);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start_a = v;
      1: start_w = v;
      2: start_z = v;
      default: start_p = v;
    endcase
  endtask

  task automatic clear_rx();
    rx_q.delete(); stop_q.delete(); par_q.delete(); addr_q.delete();
  endtask

  // One-cycle start pulse, then time done and the first tx low relative to the request edge.
  task automatic do_xfer(input int sel, input int exp_lat, input string tag);
    int n = 0;
    int first_low = -1;
    bit busy_bad = 1'b0;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    while (mon_done !== 1'b1 && n < 400) begin
      if (mon_tx === 1'b0 && first_low < 0) first_low = n;
      if (mon_busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, " done latency"}, n, exp_lat);
    if (exp_lat > 0) begin
      chk({tag, " tx low latency"}, first_low, 2);
      chk({tag, " busy held"}, {31'd0, busy_bad}, 0);
    end else begin
      chk({tag, " tx never low"}, first_low, -1);
      chk({tag, " busy at done"}, {31'd0, mon_busy}, 0);
    end
    @(negedge clk);
    chk({tag, " done one cycle"}, {31'd0, mon_done}, 0);
    chk({tag, " busy after"}, {31'd0, mon_busy}, 0);
  endtask

  initial begin
    int dc0;
    bit tx_bad;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C;
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;
    mem[16'h0012] = 8'h07; mem[16'h0013] = 8'hA5;
    start_a = 0; start_w = 0; start_z = 0; start_p = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, tx_a}, 1);
    chk("reset busy", {31'd0, busy_a}, 0);
    chk("reset done", {31'd0, done_a}, 0);
    chk("reset addr", {16'd0, addr_a}, 32'h0010);
    chk("reset addr wrap dut", {16'd0, addr_w}, 32'hFFFF);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: basic two-byte dump
    clear_rx();
    do_xfer(0, LatFull, "t1");
    repeat (5) @(negedge clk);
    chk("t1 frames", rx_q.size(), 2);
    chk("t1 byte0", {24'd0, rx_q[0]}, 32'hA5);
    chk("t1 byte1", {24'd0, rx_q[1]}, 32'h3C);
    chk("t1 stop0", {31'd0, stop_q[0]}, 1);
    chk("t1 stop1", {31'd0, stop_q[1]}, 1);
    chk("t1 addr0", {16'd0, addr_q[0]}, 32'h0010);
    chk("t1 addr1", {16'd0, addr_q[1]}, 32'h0011);
    chk("t1 done count", done_cnt, 1);

    // 2: start held high for 200 cycles
    clear_rx();
    dc0 = done_cnt;
    start_a = 1'b1;
    repeat (200) @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("t2 done count", done_cnt - dc0, 1);
    chk("t2 frames", rx_q.size(), 2);
    chk("t2 byte1", {24'd0, rx_q[1]}, 32'h3C);

    // 3: second edge mid-byte is ignored
    clear_rx();
    dc0 = done_cnt;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (150) @(negedge clk);
    chk("t3 done count", done_cnt - dc0, 1);
    chk("t3 frames", rx_q.size(), 2);
    chk("t3 byte0", {24'd0, rx_q[0]}, 32'hA5);

    // 4: reset during data bit 3 of byte 0
    clear_rx();
    dc0 = done_cnt;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (19) @(negedge clk);
    chk("t4 bit3 before reset", {31'd0, tx_a}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t4 tx after reset", {31'd0, tx_a}, 1);
    chk("t4 busy after reset", {31'd0, busy_a}, 0);
    chk("t4 done after reset", {31'd0, done_a}, 0);
    reset = 1'b0;
    tx_bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx_a !== 1'b1) tx_bad = 1'b1;
    end
    chk("t4 tx idle after abort", {31'd0, tx_bad}, 0);
    chk("t4 no done", done_cnt - dc0, 0);
    clear_rx();
    do_xfer(0, LatFull, "t4");
    repeat (5) @(negedge clk);
    chk("t4 frames", rx_q.size(), 2);
    chk("t4 byte0", {24'd0, rx_q[0]}, 32'hA5);
    chk("t4 byte1", {24'd0, rx_q[1]}, 32'h3C);
    chk("t4 addr0", {16'd0, addr_q[0]}, 32'h0010);

    // 5: address wrap and zero-length request
    mon_sel = 1;
    clear_rx();
    do_xfer(1, LatFull, "t5w");
    repeat (5) @(negedge clk);
    chk("t5w addr0", {16'd0, addr_q[0]}, 32'hFFFF);
    chk("t5w addr1", {16'd0, addr_q[1]}, 32'h0000);
    chk("t5w byte0", {24'd0, rx_q[0]}, 32'h5A);
    chk("t5w byte1", {24'd0, rx_q[1]}, 32'hC3);
    mon_sel = 2;
    clear_rx();
    do_xfer(2, 0, "t5z");
    repeat (10) @(negedge clk);
    chk("t5z frames", rx_q.size(), 0);
    chk("t5z tx", {31'd0, tx_z}, 1);

    // 6: second data set; parity bits when enabled
    mon_sel = 3;
    clear_rx();
    do_xfer(3, LatFull, "t6");
    repeat (5) @(negedge clk);
    chk("t6 byte0", {24'd0, rx_q[0]}, 32'h07);
    chk("t6 byte1", {24'd0, rx_q[1]}, 32'hA5);
    chk("t6 stop1", {31'd0, stop_q[1]}, 1);
`ifdef UART_TX_PARITY_EN
    chk("t6 parity 07", {31'd0, par_q[0]}, 1);
    chk("t6 parity A5", {31'd0, par_q[1]}, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
